// File: rtl/nanorisc_mem_pkg.sv
// Shared constants and encodings for the data memory arbiter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nanorisc_mem_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Port IDs double as bit positions in the req/grant vectors.
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DMA  = 1'b1;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Bundle of the two requester ports and the DataMemory-facing bus.
// Latency: n/a (wires only).
// Backpressure: req held until ack; one completion pulse per request.
interface data_memory_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    // Core load/store port
    logic                  c_req;
    logic                  c_we;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_wdata;
    logic                  c_ack;
    logic [DATA_WIDTH-1:0] c_rdata;

    // Debug/DMA loader port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    // Single-port DataMemory
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_writeData;
    logic                  mem_MemRead;
    logic                  mem_MemWrite;
    logic [DATA_WIDTH-1:0] mem_dataOut;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ack, d_rdata,
        output mem_address, mem_writeData, mem_MemRead, mem_MemWrite,
        input  mem_dataOut
    );

    // Requester and memory side
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  mem_address, mem_writeData, mem_MemRead, mem_MemWrite,
        output mem_dataOut
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant: on a tie, the port that did not win last time wins.
// Latency: combinational.
// Backpressure: none; caller masks ineligible requests before they get here.
module rr_arbiter2
    import nanorisc_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       owner,
    output logic [1:0] grant
);

    // Single requester passes straight through; a tie goes to the non-owner.
    always_comb begin
        grant = 2'b00;
        if (req[PORT_CORE] && req[PORT_DMA]) begin
            if (owner == PORT_DMA) begin
                grant[PORT_CORE] = 1'b1;
            end else begin
                grant[PORT_DMA] = 1'b1;
            end
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port DataMemory between the core and DMA req/ack ports.
// Latency: req sampled at E0, memory op at E1, ack high in the cycle after E2.
// Backpressure: losing/late requester holds req; at most one access per 3 cycles.
module data_memory_arbiter #(
    parameter int DATA_WIDTH = nanorisc_mem_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = nanorisc_mem_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    data_memory_arbiter_if.slave  bus,
    output logic                  busy,
    output logic                  owner
);
    import nanorisc_mem_pkg::*;

    state_t                state_q, state_d;
    logic                  cmd_port_q, cmd_port_d;
    logic                  cmd_we_q, cmd_we_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_rd_q, mem_rd_d;
    logic                  mem_wr_q, mem_wr_d;
    logic                  c_ack_q, c_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic [DATA_WIDTH-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  busy_q, busy_d;
    logic                  owner_q, owner_d;

    logic [1:0]            req_elig;
    logic [1:0]            grant;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // A port still showing its ack has not had a chance to drop req yet,
    // so it must not be granted again in that cycle.
    assign req_elig[PORT_CORE] = bus.c_req & ~c_ack_q;
    assign req_elig[PORT_DMA]  = bus.d_req & ~d_ack_q;

    rr_arbiter2 u_rr (
        .req   (req_elig),
        .owner (owner_q),
        .grant (grant)
    );

    // Select the winning port's command fields for latching.
    always_comb begin
        sel_we    = bus.c_we;
        sel_addr  = bus.c_addr;
        sel_wdata = bus.c_wdata;
        if (grant[PORT_DMA]) begin
            sel_we    = bus.d_we;
            sel_addr  = bus.d_addr;
            sel_wdata = bus.d_wdata;
        end
    end

    // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d       = state_q;
        cmd_port_d    = cmd_port_q;
        cmd_we_d      = cmd_we_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        c_ack_d       = 1'b0;
        d_ack_d       = 1'b0;
        c_rdata_d     = c_rdata_q;
        d_rdata_d     = d_rdata_q;
        busy_d        = busy_q;
        owner_d       = owner_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (|grant) begin
                    cmd_port_d    = grant[PORT_DMA] ? PORT_DMA : PORT_CORE;
                    cmd_we_d      = sel_we;
                    mem_address_d = sel_addr;
                    mem_wdata_d   = sel_wdata;
                    mem_wr_d      = sel_we;
                    mem_rd_d      = ~sel_we;
                    owner_d       = grant[PORT_DMA] ? PORT_DMA : PORT_CORE;
                    busy_d        = 1'b1;
                    state_d       = ACCESS;
                end
            end

            ACCESS: begin
                // Memory performs the op on the edge ending this cycle.
                busy_d  = 1'b1;
                state_d = RESP;
            end

            RESP: begin
                // Read data from the ACCESS edge is on mem_dataOut now.
                if (!cmd_we_q) begin
                    if (cmd_port_q == PORT_DMA) begin
                        d_rdata_d = bus.mem_dataOut;
                    end else begin
                        c_rdata_d = bus.mem_dataOut;
                    end
                end
                if (cmd_port_q == PORT_DMA) begin
                    d_ack_d = 1'b1;
                end else begin
                    c_ack_d = 1'b1;
                end
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops strobes and acks at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cmd_port_q    <= PORT_CORE;
            cmd_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
            c_ack_q       <= 1'b0;
            d_ack_q       <= 1'b0;
            c_rdata_q     <= '0;
            d_rdata_q     <= '0;
            busy_q        <= 1'b0;
            owner_q       <= PORT_DMA;
        end else begin
            state_q       <= state_d;
            cmd_port_q    <= cmd_port_d;
            cmd_we_q      <= cmd_we_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
            c_ack_q       <= c_ack_d;
            d_ack_q       <= d_ack_d;
            c_rdata_q     <= c_rdata_d;
            d_rdata_q     <= d_rdata_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
        end
    end

    assign bus.c_ack         = c_ack_q;
    assign bus.c_rdata       = c_rdata_q;
    assign bus.d_ack         = d_ack_q;
    assign bus.d_rdata       = d_rdata_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writeData = mem_wdata_q;
    assign bus.mem_MemRead   = mem_rd_q;
    assign bus.mem_MemWrite  = mem_wr_q;
    assign busy              = busy_q;
    assign owner             = owner_q;

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
Two-port arbiter/sequencer in front of the single-port DataMemory (16 x 8-bit, registered read, write on rising clock).
It shares the memory between the core load/store path (port C) and the debug/DMA loader (port D).
Each access is a req/ack transaction, and ties are resolved round-robin.
The block drives MemRead/MemWrite/address/writeData and returns read data to the winning requester.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width (16 words)

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
c_req  in  1  core request; held high with c_we/c_addr/c_wdata stable until c_ack
c_we  in  1  1 = write, 0 = read
c_addr  in  ADDR_WIDTH  core address
c_wdata  in  DATA_WIDTH  core write data
c_ack  out  1  one-cycle completion pulse
c_rdata  out  DATA_WIDTH  read data, valid while c_ack=1 and held until the next core read completes
d_req, d_we, d_addr, d_wdata, d_ack, d_rdata  same as the c_* ports, for the DMA port
mem_address  out  ADDR_WIDTH  to DataMemory address
mem_writeData  out  DATA_WIDTH  to DataMemory writeData
mem_MemRead  out  1  to DataMemory MemRead
mem_MemWrite  out  1  to DataMemory MemWrite
mem_dataOut  in  DATA_WIDTH  from DataMemory dataOut, valid the cycle after the MemRead edge
busy  out  1  high in ACCESS and RESP
owner  out  1  last/current grant: 0 = core, 1 = DMA

Behaviour:
- Reset values: all outputs 0; state = IDLE; owner = 1, so the core wins the first tie.
- All outputs are registered; no combinational req-to-mem path.
- FSM states:
  - IDLE: at a rising edge with an eligible req, latch winner, we, addr and wdata into the command registers. Set owner to the winner. Go to ACCESS.
  - ACCESS (one cycle): mem_address/mem_writeData come from the command registers. mem_MemWrite = we, mem_MemRead = ~we, never both high. At the edge ending ACCESS the memory performs the op; go to RESP.
  - RESP (one cycle): strobes return to 0. At the edge ending RESP, capture mem_dataOut into the winner's rdata (reads only; rdata is unchanged on writes). Pulse the winner's ack for the following cycle. Go to IDLE.
- Latency: req sampled at edge E0 gives memory op at E1, ack high during the cycle after E2. One transaction per 3 cycles at most.
- Eligibility: a port whose ack is high in the current cycle is not eligible. This prevents re-granting a req that has not yet dropped.
- Arbitration:
  - Only one port eligible: grant it.
  - Both eligible: grant the port not equal to owner (strict alternation).
  - Reqs arriving during ACCESS/RESP wait; nothing is queued beyond the req level.
- A req deasserted before ack is a protocol violation. The in-flight transaction completes regardless, since it runs from latched commands.
- Reset mid-transaction: strobes drop immediately (async) and no ack is issued. If reset rises before the ACCESS-ending edge, no write occurs. Memory contents themselves are not cleared.
- ack is never high on both ports in the same cycle.
- Width rules: no address arithmetic; addresses pass through unmodified and wrap is the memory's concern.

Decomposition:
- Shared package nanorisc_mem_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH constants.
  - State encoding IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port ID constants PORT_CORE=1'b0, PORT_DMA=1'b1.
- One natural sub-module, rr_arbiter2: pure 2-input round-robin grant logic with inputs (req[1:0], owner) and output grant[1:0].
- FSM and datapath registers stay in data_memory_arbiter.

Test Plan:
- Core write alone: c_req=1, c_we=1, c_addr=10, c_wdata=22.
  - Required: mem_MemWrite=1 for exactly one cycle with mem_address=10; memory word 10 = 22; c_ack one pulse 3 cycles after request; d_ack stays 0.
- Core read back: c_req=1, c_we=0, c_addr=10.
  - Required: mem_MemRead=1 for one cycle; c_rdata=22 while c_ack=1; mem_MemWrite stays 0.
- Simultaneous requests from reset: core writes 0x55 to addr 3 and DMA writes 0xAA to addr 3, both reqs held high.
  - Required: core granted first, DMA second (alternation); final word 3 = 0xAA; acks in the order c then d, 3 cycles apart.
- Sustained contention: both ports issue 4 back-to-back reads each.
  - Required: grants alternate C,D,C,D,...; owner toggles each transaction; no port is starved; acks never coincide.
- Req held through ack: c_req stays high one extra cycle after c_ack.
  - Required: no second core transaction starts in the ack cycle; busy stays 0 in that cycle when d_req=0.
- Reset mid-operation: assert reset during ACCESS of a DMA write of 0x77 to addr 5, with the write edge not yet reached.
  - Required: mem strobes 0 immediately; word 5 unchanged; d_ack never pulses; owner=1 and state IDLE after reset release.
